// File: rtl/adc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_pkg : shared constants and FSM state encoding for the ADC capture    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package adc_pkg;

    localparam int ADC_DATA_WIDTH = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_cap_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_cap_fifo : first-word-fall-through sync FIFO with synchronous flush  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adc_cap_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Wrap bit differs and index bits match: every slot holds live data.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write into a full FIFO is legal when the head leaves on the same edge.
    assign do_wr = wr_en && (!full || rd_en) && !flush;
    assign do_rd = rd_en && !empty && !flush;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_capture : calibrated-gated ADC sample capture onto a valid/ready     |
// |               stream, with overrange and overflow statistics             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH    = ADC_DATA_WIDTH,
    parameter int SETTLE_CYCLES = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int OR_CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    idelay_rdy_i,
    input  logic                    enable_i,
    input  logic                    twos_comp_i,
    input  logic                    stat_clr_i,
    input  logic [DATA_WIDTH-1:0]   adc_dat_i,
    input  logic                    adc_or_i,
    output logic [DATA_WIDTH-1:0]   m_tdata_o,
    output logic                    m_tuser_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    locked_o,
    output logic                    overflow_o,
    output logic [OR_CNT_WIDTH-1:0] or_count_o
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]           SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]           CNT_ONE     = CW'(1);
    localparam logic [OR_CNT_WIDTH-1:0] OR_ONE      = OR_CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]   MSB_MASK    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  rdy_meta;
    logic                  rdy_s;
    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         settle_cnt;
    logic [CW-1:0]         settle_cnt_nxt;
    logic                  load_fmt;
    logic                  fmt_r;
    logic                  flush;
    logic [DATA_WIDTH:0]   s1;
    logic [DATA_WIDTH:0]   s2;
    logic                  wr_en;
    logic                  rd_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;
    logic                  or_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= idelay_rdy_i;
            rdy_s    <= rdy_meta;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        load_fmt       = 1'b0;
        flush          = (state != IDLE) && !(rdy_s && enable_i);
        case (state)
            IDLE: begin
                if (rdy_s && enable_i) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                    load_fmt       = 1'b1;
                end
            end
            SETTLE: begin
                if (flush)                 state_nxt      = IDLE;
                else if (settle_cnt == '0) state_nxt      = RUN;
                else                       settle_cnt_nxt = settle_cnt - CNT_ONE;
            end
            RUN: begin
                if (flush) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            settle_cnt <= '0;
            fmt_r      <= 1'b0;
            locked_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            locked_o   <= (state == RUN);
            if (load_fmt) fmt_r <= twos_comp_i;
        end
    end

    // Offset binary becomes two's complement by flipping the sign bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else if (flush) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {adc_or_i, adc_dat_i};
            s2 <= {s1[DATA_WIDTH], s1[DATA_WIDTH-1:0] ^ (fmt_r ? MSB_MASK : '0)};
        end
    end

    assign wr_en      = (state == RUN) && !flush;
    assign rd_en      = m_tvalid_o && m_tready_i;
    assign m_tvalid_o = !fifo_empty;
    assign drop       = wr_en && fifo_full && !rd_en;
    assign or_hit     = wr_en && s2[DATA_WIDTH];

    adc_cap_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (s2),
        .full    (fifo_full),
        .rd_en   (rd_en),
        .rd_data ({m_tuser_o, m_tdata_o}),
        .empty   (fifo_empty)
    );

    // Clear wins but still records an event landing on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            or_count_o <= '0;
            overflow_o <= 1'b0;
        end else if (stat_clr_i) begin
            or_count_o <= or_hit ? OR_ONE : '0;
            overflow_o <= drop;
        end else begin
            if (or_hit && !(&or_count_o)) or_count_o <= or_count_o + OR_ONE;
            if (drop)                     overflow_o <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_capture : scoreboard bench for adc_capture                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_adc_capture;
    localparam int DW     = 14;
    localparam int SETTLE = 16;
    localparam int DEPTH  = 4;
    localparam int ORW    = 16;
    localparam int S_IDLE = 0;
    localparam int S_SET  = 1;
    localparam int S_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          idelay_rdy_i;
    logic          enable_i;
    logic          twos_comp_i;
    logic          stat_clr_i;
    logic [DW-1:0] adc_dat_i;
    logic          adc_or_i;
    logic [DW-1:0] m_tdata_o;
    logic          m_tuser_o;
    logic          m_tvalid_o;
    logic          m_tready_i;
    logic          locked_o;
    logic          overflow_o;
    logic [ORW-1:0] or_count_o;

    always #5 clk = ~clk;

    adc_capture #(
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (SETTLE),
        .FIFO_DEPTH    (DEPTH),
        .OR_CNT_WIDTH  (ORW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .idelay_rdy_i (idelay_rdy_i),
        .enable_i     (enable_i),
        .twos_comp_i  (twos_comp_i),
        .stat_clr_i   (stat_clr_i),
        .adc_dat_i    (adc_dat_i),
        .adc_or_i     (adc_or_i),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .locked_o     (locked_o),
        .overflow_o   (overflow_o),
        .or_count_o   (or_count_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [DW:0]    exp_q [$];
    logic [DW-1:0]  hist  [$];
    int             m_st  = S_IDLE;
    int             m_cnt = 0;
    logic           m_rdy_m = 1'b0, m_rdy_s = 1'b0, m_fmt = 1'b0;
    logic           m_lock = 1'b0, m_ovf = 1'b0;
    logic [ORW-1:0] m_orc = '0;
    logic [DW:0]    m_s1 = '0, m_s2 = '0;

    int            mode = 0;
    int            pat_idx = 0;
    logic [DW-1:0] pat [3] = '{14'h0000, 14'h2000, 14'h3FFF};

    task automatic compare_outputs();
        check("valid", m_tvalid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("data", m_tdata_o, exp_q[0][DW-1:0]);
            check("user", m_tuser_o, exp_q[0][DW]);
        end
        check("locked", locked_o, m_lock);
        check("overflow", overflow_o, m_ovf);
        check("or_count", or_count_o, m_orc);
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        logic        rd, flush, wr, drop, hit;
        logic [DW:0] s2_new;
        hist.push_back(adc_dat_i);
        s2_new = {m_s1[DW], m_s1[DW-1] ^ m_fmt, m_s1[DW-2:0]};
        rd    = (exp_q.size() != 0) && m_tready_i;
        flush = (m_st != S_IDLE) && !(m_rdy_s && enable_i);
        wr    = (m_st == S_RUN) && !flush;
        drop  = wr && (exp_q.size() == DEPTH) && !rd;
        hit   = wr && m_s2[DW];
        if (stat_clr_i) begin
            m_orc = hit ? 16'd1 : 16'd0;
            m_ovf = drop;
        end else begin
            if (hit && m_orc != 16'hFFFF) m_orc = m_orc + 16'd1;
            if (drop) m_ovf = 1'b1;
        end
        if (flush) exp_q.delete();
        else begin
            if (rd) void'(exp_q.pop_front());
            if (wr && !drop) exp_q.push_back(m_s2);
        end
        m_lock = (m_st == S_RUN);
        case (m_st)
            S_IDLE: if (m_rdy_s && enable_i) begin
                m_st = S_SET; m_cnt = SETTLE - 1; m_fmt = twos_comp_i;
            end
            S_SET: begin
                if (flush) m_st = S_IDLE;
                else if (m_cnt == 0) m_st = S_RUN;
                else m_cnt--;
            end
            default: if (flush) m_st = S_IDLE;
        endcase
        m_s2 = flush ? '0 : s2_new;
        m_s1 = flush ? '0 : {adc_or_i, adc_dat_i};
        m_rdy_s = m_rdy_m;
        m_rdy_m = idelay_rdy_i;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        model_step();
        @(posedge clk);
        #1;
        if (mode == 0) adc_dat_i = adc_dat_i + 14'd1;
        else begin
            adc_dat_i = pat[pat_idx];
            pat_idx   = (pat_idx + 1) % 3;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edges from the stimulus change until locked_o is seen high.
    task automatic wait_lock(input string tag, input int exp_edges);
        int n = 0;
        while (!locked_o && n < 60) begin
            tick();
            n++;
        end
        check(tag, n, exp_edges);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int e;
        rst = 1'b1;
        idelay_rdy_i = 1'b0; enable_i = 1'b1; twos_comp_i = 1'b0; stat_clr_i = 1'b0;
        adc_dat_i = '0; adc_or_i = 1'b0; m_tready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_locked", locked_o, 0);
        check("rst_valid", m_tvalid_o, 0);
        check("rst_orcnt", or_count_o, 0);
        check("rst_ovf", overflow_o, 0);

        // T1: enabled but not calibrated, nothing may flow
        ticks(100);
        check("t1_locked", locked_o, 0);
        check("t1_valid", m_tvalid_o, 0);

        // T2: 2 sync edges, 1 edge into SETTLE, 16 settle cycles, 1 for the flag
        idelay_rdy_i = 1'b1;
        wait_lock("t2_lock_latency", 20);
        w = 0;
        while (!m_tvalid_o && w < 10) begin
            tick();
            w++;
        end
        check("t2_first_valid", m_tvalid_o, 1);
        e = hist.size();
        check("t2_first_sample", m_tdata_o, hist[e-3]);
        ticks(20);

        // T3: re-arm with two's complement formatting, fixed pattern
        enable_i = 1'b0;
        ticks(3);
        twos_comp_i = 1'b1;
        enable_i    = 1'b1;
        wait_lock("t3_lock_latency", 18);
        mode = 1;
        ticks(12);
        mode = 0;

        // T4: backpressure fills the FIFO and drops samples
        m_tready_i = 1'b0;
        ticks(10);
        check("t4_overflow", overflow_o, 1);
        check("t4_valid_held", m_tvalid_o, 1);
        m_tready_i = 1'b1;
        ticks(12);

        // T5: five overrange samples, clear coincident with the fifth being counted
        adc_or_i = 1'b1;
        ticks(5);
        adc_or_i = 1'b0;
        tick();
        stat_clr_i = 1'b1;
        tick();
        stat_clr_i = 1'b0;
        tick();
        check("t5_or_count", or_count_o, 1);
        check("t5_ovf_cleared", overflow_o, 0);
        ticks(6);

        // T6: lose calibration while stalled, then recover
        m_tready_i = 1'b0;
        ticks(3);
        idelay_rdy_i = 1'b0;
        ticks(3);
        check("t6_flush_valid", m_tvalid_o, 0);
        ticks(2);
        check("t6_unlocked", locked_o, 0);
        m_tready_i   = 1'b1;
        idelay_rdy_i = 1'b1;
        wait_lock("t6_relock_latency", 20);
        ticks(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
